// File: rtl/mem_bus_decoder.sv
// Routes PicoRV32 native memory requests to the SRAM controller or the IO port.
// Unmapped addresses and timed-out slaves complete with zero data and set sticky error flags.
module mem_bus_decoder #(
  parameter logic [7:0]  TIMEOUT    = 8'd64,
  parameter logic [15:0] IO_BASE_HI = 16'h1000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,

  output logic        sram_mem_valid,
  output logic [31:0] sram_mem_addr,
  output logic [31:0] sram_mem_wdata,
  output logic [3:0]  sram_mem_wstrb,
  input  logic        sram_mem_ready,
  input  logic [31:0] sram_mem_rdata,

  output logic        io_mem_valid,
  output logic [31:0] io_mem_addr,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wstrb,
  input  logic        io_mem_ready,
  input  logic [31:0] io_mem_rdata,

  output logic [1:0]  err_status,
  output logic [31:0] err_addr,
  input  logic        err_clear
);

  localparam logic [7:0] TimeoutLast = TIMEOUT - 8'd1;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSramWait = 2'd1,
    StIoWait   = 2'd2,
    StResp     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic        sram_valid_q, sram_valid_d;
  logic        io_valid_q, io_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_status_q, err_status_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        sel_sram, sel_io;
  logic        new_unmapped, new_timeout;
  logic        is_read;
  logic [1:0]  err_base_status;
  logic [31:0] err_base_addr;

  assign sel_sram = (cpu_mem_addr[31:19] == 13'd0);
  assign sel_io   = (cpu_mem_addr[31:16] == IO_BASE_HI);
  assign is_read  = (req_wstrb_q == 4'd0);

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    sram_valid_d = sram_valid_q;
    io_valid_d   = io_valid_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    new_unmapped = 1'b0;
    new_timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_mem_valid) begin
          req_addr_d  = cpu_mem_addr;
          req_wdata_d = cpu_mem_wdata;
          req_wstrb_d = cpu_mem_wstrb;
          rdata_d     = 32'd0;
          cnt_d       = 8'd0;
          if (sel_sram) begin
            sram_valid_d = 1'b1;
            state_d      = StSramWait;
          end else if (sel_io) begin
            io_valid_d = 1'b1;
            state_d    = StIoWait;
          end else begin
            new_unmapped = 1'b1;
            state_d      = StResp;
          end
        end
      end
      StSramWait: begin
        // Ready beats timeout when both land in the same cycle.
        if (sram_mem_ready) begin
          sram_valid_d = 1'b0;
          rdata_d      = is_read ? sram_mem_rdata : 32'd0;
          state_d      = StResp;
        end else if (cnt_q == TimeoutLast) begin
          sram_valid_d = 1'b0;
          rdata_d      = 32'd0;
          new_timeout  = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIoWait: begin
        if (io_mem_ready) begin
          io_valid_d = 1'b0;
          rdata_d    = is_read ? io_mem_rdata : 32'd0;
          state_d    = StResp;
        end else if (cnt_q == TimeoutLast) begin
          io_valid_d  = 1'b0;
          rdata_d     = 32'd0;
          new_timeout = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d      = StIdle;
        sram_valid_d = 1'b0;
        io_valid_d   = 1'b0;
      end
    endcase
  end

  // A clear in the same cycle as a new error behaves as if the flags were already empty.
  always_comb begin
    err_base_status = err_clear ? 2'b00 : err_status_q;
    err_base_addr   = err_clear ? 32'd0 : err_addr_q;
    err_status_d    = err_base_status | {new_timeout, new_unmapped};
    err_addr_d      = err_base_addr;
    if ((new_unmapped || new_timeout) && (err_base_status == 2'b00)) begin
      err_addr_d = new_unmapped ? cpu_mem_addr : req_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 32'd0;
      req_wstrb_q  <= 4'd0;
      sram_valid_q <= 1'b0;
      io_valid_q   <= 1'b0;
      rdata_q      <= 32'd0;
      cnt_q        <= 8'd0;
      err_status_q <= 2'b00;
      err_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wstrb_q  <= req_wstrb_d;
      sram_valid_q <= sram_valid_d;
      io_valid_q   <= io_valid_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      err_status_q <= err_status_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign cpu_mem_ready  = (state_q == StResp);
  assign cpu_mem_rdata  = rdata_q;

  assign sram_mem_valid = sram_valid_q;
  assign sram_mem_addr  = req_addr_q;
  assign sram_mem_wdata = req_wdata_q;
  assign sram_mem_wstrb = req_wstrb_q;

  assign io_mem_valid   = io_valid_q;
  assign io_mem_addr    = req_addr_q;
  assign io_mem_wdata   = req_wdata_q;
  assign io_mem_wstrb   = req_wstrb_q;

  assign err_status     = err_status_q;
  assign err_addr       = err_addr_q;

endmodule

// File: doc/mem_bus_decoder.md
MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd64: slave-wait cycles before forced completion.
REQ-002 SHALL have parameter IO_BASE_HI, default 16'h1000: value of addr[31:16] selecting the IO region.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_mem_valid/cpu_mem_addr/cpu_mem_wdata/cpu_mem_wstrb  in  1/32/32/4  PicoRV32 request; held until cpu_mem_ready.
REQ-006 cpu_mem_ready  out  1  one-cycle completion pulse; cpu_mem_rdata  out  32  read data, valid with ready.
REQ-007 sram_mem_valid/sram_mem_addr/sram_mem_wdata/sram_mem_wstrb  out  1/32/32/4  request to SRAM controller.
REQ-008 sram_mem_ready/sram_mem_rdata  in  1/32  SRAM controller completion and data.
REQ-009 io_mem_valid/io_mem_addr/io_mem_wdata/io_mem_wstrb  out  1/32/32/4; io_mem_ready/io_mem_rdata  in  1/32  IO peripheral port, same protocol.
REQ-010 err_status  out  2  sticky: bit0 unmapped access, bit1 timeout; err_addr  out  32  address of first error; err_clear  in  1  clears both.

Function
REQ-011 Decode: SRAM when addr[31:19]==0 (512 KB); IO when addr[31:16]==IO_BASE_HI; otherwise unmapped.
REQ-012 States IDLE, SRAM_WAIT, IO_WAIT, RESP; encoding free, unused encodings return to IDLE.
REQ-013 IDLE, cpu_mem_valid=1: register addr/wdata/wstrb into one shared request register driving both slave addr/wdata/wstrb buses; raise selected slave valid; go SRAM_WAIT/IO_WAIT; unmapped goes to RESP with rdata 0.
REQ-014 Request register SHALL stay constant from acceptance until return to IDLE (SRAM controller re-reads addr mid-transaction).
REQ-015 *_WAIT, slave ready=1: capture slave rdata (reads) or 0 (writes), deassert slave valid at that edge, go RESP.
REQ-016 RESP: cpu_mem_ready=1 for exactly one cycle, then IDLE; no new request accepted in RESP.
REQ-017 Slave valid SHALL be low no later than the edge after slave ready, so a slave re-entering idle never sees a stale valid.
REQ-018 SRAM latency: cpu sees ready 2 cycles after sram_mem_ready; unmapped: ready 2 cycles after acceptance (IDLE->RESP->ready).
REQ-019 Wait counter (8-bit) clears on entering *_WAIT, increments per WAIT cycle; at count==TIMEOUT-1 without ready: drop slave valid, rdata=0, set err_status[1], go RESP.
REQ-020 Slave ready arriving outside its own *_WAIT state (e.g. late after timeout) SHALL be ignored.
REQ-021 Ready and timeout in the same cycle: ready wins, no error.
REQ-022 Unmapped access SHALL set err_status[0]; writes dropped, no slave valid asserted.
REQ-023 err_addr loads request address only when err_status==0 before the event; err_clear zeroes err_status and err_addr; err_clear with simultaneous new error: new error wins.
REQ-024 wstrb passed unmodified; decoder performs no byte lane manipulation or alignment checks.

Reset
REQ-025 On reset: state IDLE, all valid/ready outputs 0, cpu_mem_rdata 0, request register 0, counter 0, err_status 0, err_addr 0.
REQ-026 Reset mid-transaction SHALL abort immediately; no cpu_mem_ready issued for the aborted request.

Verification
REQ-027 SRAM read addr 0x0000_0100, sram returns 0xCAFE_F00D after 4 cycles -> cpu_mem_rdata 0xCAFE_F00D, single ready pulse, sram_mem_addr stable throughout.
REQ-028 IO write addr 0x1000_0004, wdata 0x55, wstrb 4'b0001 -> io_mem_valid with identical fields, sram_mem_valid stays 0, cpu ready after io ready.
REQ-029 Read addr 0x2000_0000 -> rdata 0, ready 2 cycles after acceptance, err_status 2'b01, err_addr 0x2000_0000.
REQ-030 IO slave never ready, TIMEOUT=64 -> ready after 64 wait cycles, rdata 0, err_status[1]=1; later stray io_mem_ready ignored.
REQ-031 Back-to-back SRAM write then read -> each slave valid drops before SRAM controller returns to idle; exactly two slave transactions observed.
REQ-032 Reset asserted in SRAM_WAIT -> next cycle all outputs at reset values, no cpu_mem_ready pulse.
